// File: rtl/child_seq_ctrl.sv
// Start/done sequencer for the leaf children of a hierarchy node: launches each
// enabled child in ascending order and records whether it answered or timed out.
module child_seq_ctrl #(
    parameter int NUM_CHILD = 5,
    parameter int TIMEOUT_W = 8,
    parameter int IDX_W     = (NUM_CHILD > 1) ? $clog2(NUM_CHILD) : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 abort,
    input  logic [NUM_CHILD-1:0] child_en,
    input  logic [TIMEOUT_W-1:0] timeout_limit,
    output logic [NUM_CHILD-1:0] child_start,
    input  logic [NUM_CHILD-1:0] child_done,
    output logic                 busy,
    output logic [IDX_W-1:0]     cur_idx,
    output logic                 seq_done,
    output logic [NUM_CHILD-1:0] pass_mask,
    output logic [NUM_CHILD-1:0] tmo_mask
);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, FINISH} state_t;

    state_t               state, state_d;
    logic [NUM_CHILD-1:0] en_q, en_q_d;
    logic [TIMEOUT_W-1:0] lim_q, lim_q_d;
    logic [TIMEOUT_W-1:0] cnt, cnt_d;
    logic [IDX_W-1:0]     cur_idx_d;
    logic [NUM_CHILD-1:0] pass_d, tmo_d, start_d;
    logic                 busy_d, seq_done_d;
    logic                 first_found, next_found, advance;
    logic [IDX_W-1:0]     first_idx, next_idx;

    // Outputs are computed from the next state so every output leaves a flop.
    always_comb begin
        state_d     = state;
        en_q_d      = en_q;
        lim_q_d     = lim_q;
        cnt_d       = cnt;
        cur_idx_d   = cur_idx;
        pass_d      = pass_mask;
        tmo_d       = tmo_mask;
        advance     = 1'b0;
        first_found = 1'b0;
        first_idx   = '0;
        next_found  = 1'b0;
        next_idx    = '0;

        // Scanning downward leaves the lowest qualifying bit as the winner.
        for (int i = NUM_CHILD - 1; i >= 0; i--) begin
            if (child_en[i]) begin
                first_found = 1'b1;
                first_idx   = IDX_W'(i);
            end
            if (en_q[i] && (IDX_W'(i) > cur_idx)) begin
                next_found = 1'b1;
                next_idx   = IDX_W'(i);
            end
        end

        case (state)
            IDLE: begin
                if (go) begin
                    en_q_d  = child_en;
                    lim_q_d = timeout_limit;
                    pass_d  = '0;
                    tmo_d   = '0;
                    if (first_found) begin
                        cur_idx_d = first_idx;
                        state_d   = LAUNCH;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            LAUNCH: begin
                cnt_d   = '0;
                state_d = abort ? FINISH : WAIT;
            end
            WAIT: begin
                if (child_done[cur_idx]) begin
                    pass_d[cur_idx] = 1'b1;
                    advance         = 1'b1;
                end else if (cnt == lim_q) begin
                    if (!abort) begin
                        tmo_d[cur_idx] = 1'b1;
                    end
                    advance = 1'b1;
                end else begin
                    cnt_d = cnt + 1'b1;
                end
                if (abort) begin
                    state_d = FINISH;
                end else if (advance) begin
                    if (next_found) begin
                        cur_idx_d = next_idx;
                        state_d   = LAUNCH;
                    end else begin
                        state_d = FINISH;
                    end
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        start_d = '0;
        if (state_d == LAUNCH) begin
            start_d[cur_idx_d] = 1'b1;
        end
        busy_d     = (state_d == LAUNCH) || (state_d == WAIT);
        seq_done_d = (state_d == FINISH);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            en_q        <= '0;
            lim_q       <= '0;
            cnt         <= '0;
            cur_idx     <= '0;
            pass_mask   <= '0;
            tmo_mask    <= '0;
            child_start <= '0;
            busy        <= 1'b0;
            seq_done    <= 1'b0;
        end else begin
            state       <= state_d;
            en_q        <= en_q_d;
            lim_q       <= lim_q_d;
            cnt         <= cnt_d;
            cur_idx     <= cur_idx_d;
            pass_mask   <= pass_d;
            tmo_mask    <= tmo_d;
            child_start <= start_d;
            busy        <= busy_d;
            seq_done    <= seq_done_d;
        end
    end

endmodule

// File: tb/tb_child_seq_ctrl.sv
// Scoreboard bench for child_seq_ctrl: expected start pulses and end-of-sequence
// results are queued with their cycle numbers and matched as the DUT produces them.
module tb_child_seq_ctrl;

    localparam int N  = 5;
    localparam int TW = 8;
    localparam int IW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          go;
    logic          abort;
    logic [N-1:0]  child_en;
    logic [TW-1:0] timeout_limit;
    logic [N-1:0]  child_start;
    logic [N-1:0]  child_done;
    logic          busy;
    logic [IW-1:0] cur_idx;
    logic          seq_done;
    logic [N-1:0]  pass_mask;
    logic [N-1:0]  tmo_mask;

    logic [N-1:0]  resp_done  = '0;
    logic [N-1:0]  extra_done = '0;
    int            resp_dly[N];
    int            rcnt[N] = '{default: -1};
    int            cyc = 0;
    int            n_checks = 0;
    int            n_fail = 0;

    typedef struct {int at; logic [N-1:0] start;} start_exp_t;
    typedef struct {int at; logic [N-1:0] pass; logic [N-1:0] tmo;} done_exp_t;
    start_exp_t start_q[$];
    done_exp_t  done_q[$];

    assign child_done = resp_done | extra_done;

    child_seq_ctrl #(.NUM_CHILD(N), .TIMEOUT_W(TW), .IDX_W(IW)) dut (
        .clk           (clk),
        .rst           (rst),
        .go            (go),
        .abort         (abort),
        .child_en      (child_en),
        .timeout_limit (timeout_limit),
        .child_start   (child_start),
        .child_done    (child_done),
        .busy          (busy),
        .cur_idx       (cur_idx),
        .seq_done      (seq_done),
        .pass_mask     (pass_mask),
        .tmo_mask      (tmo_mask)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic pushStart(input int at, input logic [N-1:0] start);
        start_exp_t e;
        e.at    = at;
        e.start = start;
        start_q.push_back(e);
    endtask

    task automatic pushDone(input int at, input logic [N-1:0] pass, input logic [N-1:0] tmo);
        done_exp_t e;
        e.at   = at;
        e.pass = pass;
        e.tmo  = tmo;
        done_q.push_back(e);
    endtask

    // Called just after a falling edge; returns at the falling edge of the cycle after go.
    task automatic applyStimulus(input logic [N-1:0] en, input logic [TW-1:0] lim);
        child_en      = en;
        timeout_limit = lim;
        go            = 1'b1;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while ((start_q.size() != 0 || done_q.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("seq_complete", 32'(start_q.size() + done_q.size()), 32'd0);
        start_q.delete();
        done_q.delete();
        repeat (3) @(negedge clk);
    endtask

    // Child responder plus scoreboard monitor, both on the falling edge.
    always @(negedge clk) begin
        logic [N-1:0] nd;
        start_exp_t   se;
        done_exp_t    de;
        int           idx;
        nd = '0;
        for (int i = 0; i < N; i++) begin
            if (child_start[i] === 1'b1) rcnt[i] = resp_dly[i];
            if (rcnt[i] == 0) nd[i] = 1'b1;
            if (rcnt[i] >= 0) rcnt[i] = rcnt[i] - 1;
        end
        resp_done = nd;

        if (!$isunknown(child_start) && child_start != '0) begin
            if (start_q.size() == 0) begin
                checkOutput("unexpected_start", 32'(child_start), 32'd0);
            end else begin
                se  = start_q.pop_front();
                idx = 0;
                for (int i = 0; i < N; i++) if (se.start[i]) idx = i;
                checkOutput("start_value", 32'(child_start), 32'(se.start));
                checkOutput("start_cycle", 32'(cyc), 32'(se.at));
                checkOutput("busy_launch", 32'(busy), 32'd1);
                checkOutput("cur_idx", 32'(cur_idx), 32'(idx));
            end
        end

        if (seq_done === 1'b1) begin
            if (done_q.size() == 0) begin
                checkOutput("unexpected_seq_done", 32'(seq_done), 32'd0);
            end else begin
                de = done_q.pop_front();
                checkOutput("done_cycle", 32'(cyc), 32'(de.at));
                checkOutput("pass_mask", 32'(pass_mask), 32'(de.pass));
                checkOutput("tmo_mask", 32'(tmo_mask), 32'(de.tmo));
                checkOutput("busy_finish", 32'(busy), 32'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c;
        rst           = 1'b1;
        go            = 1'b0;
        abort         = 1'b0;
        child_en      = '0;
        timeout_limit = '0;
        for (int i = 0; i < N; i++) resp_dly[i] = -1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_child_start", 32'(child_start), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_cur_idx", 32'(cur_idx), 32'd0);
        checkOutput("rst_seq_done", 32'(seq_done), 32'd0);
        checkOutput("rst_pass_mask", 32'(pass_mask), 32'd0);
        checkOutput("rst_tmo_mask", 32'(tmo_mask), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        $display("[TB] go with no children enabled");
        c = cyc;
        pushDone(c + 1, 5'b00000, 5'b00000);
        applyStimulus(5'b00000, 8'd8);
        waitIdle(20);

        $display("[TB] all five children, fast done");
        for (int i = 0; i < N; i++) resp_dly[i] = 1;
        c = cyc;
        pushStart(c + 1, 5'b00001);
        pushStart(c + 3, 5'b00010);
        pushStart(c + 5, 5'b00100);
        pushStart(c + 7, 5'b01000);
        pushStart(c + 9, 5'b10000);
        pushDone(c + 11, 5'b11111, 5'b00000);
        applyStimulus(5'b11111, 8'd8);
        waitIdle(40);
        checkOutput("mask_hold", 32'(pass_mask), 32'h1f);

        $display("[TB] sparse enable with timeout");
        resp_dly[2] = -1;
        resp_dly[4] = 2;
        c = cyc;
        pushStart(c + 1, 5'b00100);
        pushStart(c + 6, 5'b10000);
        pushDone(c + 9, 5'b10000, 5'b00100);
        applyStimulus(5'b10100, 8'd3);
        waitIdle(40);

        $display("[TB] done filtering");
        resp_dly[0] = 0;
        c = cyc;
        pushStart(c + 1, 5'b00001);
        pushDone(c + 5, 5'b00000, 5'b00001);
        applyStimulus(5'b00001, 8'd2);
        @(negedge clk);
        extra_done = 5'b01000;
        @(negedge clk);
        extra_done = 5'b00000;
        waitIdle(40);

        $display("[TB] abort with same-cycle done");
        for (int i = 0; i < N; i++) resp_dly[i] = 1;
        resp_dly[1] = 2;
        c = cyc;
        pushStart(c + 1, 5'b00001);
        pushStart(c + 3, 5'b00010);
        pushDone(c + 6, 5'b00011, 5'b00000);
        applyStimulus(5'b11111, 8'd8);
        repeat (4) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        waitIdle(40);
        repeat (10) @(negedge clk);

        $display("[TB] ignored go and reset mid-run");
        for (int i = 0; i < N; i++) resp_dly[i] = 1;
        c = cyc;
        pushStart(c + 1, 5'b00001);
        pushStart(c + 3, 5'b00010);
        pushStart(c + 5, 5'b00100);
        applyStimulus(5'b11111, 8'd8);
        @(negedge clk);
        go            = 1'b1;
        child_en      = 5'b00001;
        timeout_limit = 8'd0;
        @(negedge clk);
        go = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checkOutput("midrst_child_start", 32'(child_start), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_pass_mask", 32'(pass_mask), 32'd0);
        checkOutput("midrst_tmo_mask", 32'(tmo_mask), 32'd0);
        checkOutput("midrst_seq_done", 32'(seq_done), 32'd0);
        checkOutput("midrst_pending", 32'(start_q.size()), 32'd0);
        rst = 1'b0;
        start_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);

        $display("[TB] single child after reset");
        c = cyc;
        pushStart(c + 1, 5'b00010);
        pushDone(c + 3, 5'b00010, 5'b00000);
        applyStimulus(5'b00010, 8'd5);
        waitIdle(20);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
